// File: rtl/crc_pkg.sv
// crc_pkg: shared CRC helpers, FSM state type and standard algorithm presets.
package crc_pkg;

    typedef enum logic [0:0] {ACCUM, RESULT} crc_state_t;

    typedef struct packed {
        logic [31:0] poly;
        logic [31:0] init;
        logic [31:0] xor_out;
        logic        refin;
        logic        refout;
    } crc_preset_t;

    localparam crc_preset_t CRC8_SENSIRION    = '{32'h31, 32'hFF, 32'h0, 1'b0, 1'b0};
    localparam crc_preset_t CRC16_CCITT_FALSE = '{32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0};
    localparam crc_preset_t CRC32_ETH         = '{32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1};

    function automatic logic [7:0] reflect8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Reverses the low w bits of v; bits at and above w come back zero.
    function automatic logic [31:0] reflect(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (i < w) r[i] = v[w-1-i];
        return r;
    endfunction

endpackage

// File: rtl/crc_byte_update.sv
// crc_byte_update: folds one byte into a CRC register, MSB-first, fully combinational.
module crc_byte_update
    import crc_pkg::*;
#(
    parameter int               CRC_W      = 8,
    parameter logic [CRC_W-1:0] POLY       = 'h31,
    parameter bit               REFLECT_IN = 1'b0
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] crc_out
);

    logic [7:0]       b;
    logic [CRC_W-1:0] c;

    assign b = REFLECT_IN ? reflect8(data) : data;

    always_comb begin
        c = crc_in ^ (CRC_W'(b) << (CRC_W - 8));
        for (int i = 0; i < 8; i++)
            c = c[CRC_W-1] ? ((c << 1) ^ POLY) : (c << 1);
    end

    assign crc_out = c;

endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: parametrised multi-byte streaming CRC with valid/ready in and out.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W       = 8,
    parameter logic [CRC_W-1:0] POLY        = 'h31,
    parameter logic [CRC_W-1:0] INIT        = '1,
    parameter logic [CRC_W-1:0] XOR_OUT     = '0,
    parameter bit               REFLECT_IN  = 1'b0,
    parameter bit               REFLECT_OUT = 1'b0,
    parameter logic [CRC_W-1:0] RESIDUE     = '0,
    parameter int               DATA_BYTES  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               abort,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_BYTES*8-1:0]            in_data,
    input  logic [$clog2(DATA_BYTES+1)-1:0]    in_bytes,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CRC_W-1:0]                   out_crc,
    output logic                               out_match
);

    localparam int BW = $clog2(DATA_BYTES + 1);

    crc_state_t       state;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] stage [DATA_BYTES+1];
    logic [CRC_W-1:0] upd [DATA_BYTES];
    logic [BW-1:0]    n_eff;
    logic [CRC_W-1:0] raw;
    logic [CRC_W-1:0] fin;

    assign n_eff    = (in_bytes > BW'(DATA_BYTES)) ? BW'(DATA_BYTES) : in_bytes;
    assign stage[0] = crc_q;

    // Each stage either folds its byte or passes the register through untouched.
    for (genvar g = 0; g < DATA_BYTES; g++) begin : g_chain
        crc_byte_update #(.CRC_W(CRC_W), .POLY(POLY), .REFLECT_IN(REFLECT_IN)) u_step (
            .crc_in (stage[g]),
            .data   (in_data[8*g +: 8]),
            .crc_out(upd[g])
        );
        assign stage[g+1] = (BW'(g) < n_eff) ? upd[g] : stage[g];
    end

    assign raw = stage[DATA_BYTES];
    assign fin = (REFLECT_OUT ? CRC_W'(reflect(32'(raw), CRC_W)) : raw) ^ XOR_OUT;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == RESULT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q     <= INIT;
            state     <= ACCUM;
            out_crc   <= '0;
            out_match <= 1'b0;
        end else if (abort) begin
            crc_q <= INIT;
            state <= ACCUM;
        end else if (state == ACCUM && in_valid) begin
            crc_q <= in_last ? INIT : raw;
            if (in_last) begin
                state     <= RESULT;
                out_crc   <= fin;
                out_match <= (raw == RESIDUE);
            end
        end else if (state == RESULT && out_ready) begin
            state <= ACCUM;
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: three CRC configurations checked against a bit-serial reference model.
module tb_crc_stream_engine;

    logic        clk = 1'b0, reset = 1'b1, abort = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic [3:0]  in_bytes = '0;
    int          sel = 0;
    int          checks = 0, failures = 0;

    logic [2:0]  v, ordy, ovld, omat;
    logic [7:0]  oc0;
    logic [15:0] oc1;
    logic [31:0] oc2;
    logic [31:0] ocrc [3];

    always #5 clk = ~clk;

    assign v[0] = in_valid && sel == 0;
    assign v[1] = in_valid && sel == 1;
    assign v[2] = in_valid && sel == 2;

    always_comb begin
        ocrc[0] = 32'(oc0);
        ocrc[1] = 32'(oc1);
        ocrc[2] = oc2;
    end

    crc_stream_engine #(.CRC_W(8), .POLY(8'h31), .INIT(8'hFF), .DATA_BYTES(1)) dut8 (
        .clk(clk), .reset(reset), .abort(abort), .in_valid(v[0]), .in_ready(ordy[0]),
        .in_data(in_data[7:0]), .in_bytes(in_bytes[0:0]), .in_last(in_last),
        .out_valid(ovld[0]), .out_ready(out_ready), .out_crc(oc0), .out_match(omat[0]));

    crc_stream_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .DATA_BYTES(4)) dut16 (
        .clk(clk), .reset(reset), .abort(abort), .in_valid(v[1]), .in_ready(ordy[1]),
        .in_data(in_data[31:0]), .in_bytes(in_bytes[2:0]), .in_last(in_last),
        .out_valid(ovld[1]), .out_ready(out_ready), .out_crc(oc1), .out_match(omat[1]));

    crc_stream_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                        .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1),
                        .DATA_BYTES(8)) dut32 (
        .clk(clk), .reset(reset), .abort(abort), .in_valid(v[2]), .in_ready(ordy[2]),
        .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
        .out_valid(ovld[2]), .out_ready(out_ready), .out_crc(oc2), .out_match(omat[2]));

    int          cw  [3] = '{8, 16, 32};
    logic [31:0] cp  [3] = '{32'h31, 32'h1021, 32'h04C11DB7};
    logic [31:0] ci  [3] = '{32'hFF, 32'hFFFF, 32'hFFFFFFFF};
    logic [31:0] cx  [3] = '{32'h0, 32'h0, 32'hFFFFFFFF};
    bit          crf [3] = '{1'b0, 1'b0, 1'b1};
    int          cnb [3] = '{1, 4, 8};
    logic [3:0]  cbm [3] = '{4'h1, 4'h7, 4'hF};

    logic [31:0] run [3], rc [3];
    bit          busy [3], rm [3];

    function automatic logic [31:0] wmask(int d);
        return 32'((64'd1 << cw[d]) - 64'd1);
    endfunction

    // Textbook bit-at-a-time division: feedback = register MSB xor next message bit.
    function automatic logic [31:0] mbyte(int d, logic [31:0] c, logic [7:0] b);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[cw[d]-1] ^ (crf[d] ? b[i] : b[7-i]);
            c  = (c << 1) & wmask(d);
            if (fb) c = c ^ cp[d];
        end
        return c;
    endfunction

    function automatic logic [31:0] mfinal(int d, logic [31:0] c);
        logic [31:0] r;
        r = c;
        if (crf[d]) begin
            r = '0;
            for (int i = 0; i < cw[d]; i++) r[i] = c[cw[d]-1-i];
        end
        return r ^ cx[d];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                run[d] = ci[d]; busy[d] = 1'b0; rc[d] = '0; rm[d] = 1'b0;
            end else if (abort) begin
                run[d] = ci[d]; busy[d] = 1'b0;
            end else if (!busy[d] && v[d]) begin
                int n;
                n = int'(in_bytes & cbm[d]);
                if (n > cnb[d]) n = cnb[d];
                for (int k = 0; k < n; k++) run[d] = mbyte(d, run[d], in_data[8*k +: 8]);
                if (in_last) begin
                    rc[d] = mfinal(d, run[d]); rm[d] = (run[d] == 0); busy[d] = 1'b1; run[d] = ci[d];
                end
            end else if (busy[d] && out_ready) begin
                busy[d] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("in_ready[%0d]", d), 32'(ordy[d]), 32'(!busy[d]));
            chk($sformatf("out_valid[%0d]", d), 32'(ovld[d]), 32'(busy[d]));
            if (busy[d]) begin
                chk($sformatf("out_crc[%0d]", d), ocrc[d], rc[d]);
                chk($sformatf("out_match[%0d]", d), 32'(omat[d]), 32'(rm[d]));
            end
        end
    end

    task automatic beat(int d, logic [63:0] data, int nb, bit last);
        sel = d; in_valid = 1'b1; in_data = data; in_bytes = 4'(nb); in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic result(int d, logic [31:0] crc, bit m, string name);
        chk({name, " valid"}, 32'(ovld[d]), 32'd1);
        chk({name, " crc"}, ocrc[d], crc);
        chk({name, " model"}, rc[d], crc);
        chk({name, " match"}, 32'(omat[d]), 32'(m));
        chk({name, " ready_low"}, 32'(ordy[d]), 32'd0);
        repeat (5) begin
            @(posedge clk); #1;
            chk({name, " hold crc"}, ocrc[d], crc);
            chk({name, " hold ready"}, 32'(ordy[d]), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " ready_back"}, 32'(ordy[d]), 32'd1);
        chk({name, " valid_gone"}, 32'(ovld[d]), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset in_ready", 32'(ordy[d]), 32'd1);
            chk("reset out_valid", 32'(ovld[d]), 32'd0);
            chk("reset out_crc", ocrc[d], 32'd0);
            chk("reset out_match", 32'(omat[d]), 32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        beat(0, 64'hBE, 1, 1'b0);
        beat(0, 64'hEF, 1, 1'b1);
        result(0, 32'h92, 1'b0, "crc8 beef");

        for (int k = 0; k < 9; k++) beat(0, 64'(8'h31 + k), 1, k == 8);
        result(0, 32'hF7, 1'b0, "crc8 check");

        beat(0, 64'hBE, 1, 1'b0);
        beat(0, 64'hEF, 1, 1'b0);
        beat(0, 64'h92, 1, 1'b1);
        result(0, 32'h00, 1'b1, "crc8 residue");

        beat(1, 64'h34333231, 4, 1'b0);
        beat(1, 64'h38373635, 4, 1'b0);
        beat(1, 64'hFFFFFF39, 1, 1'b1);
        result(1, 32'h29B1, 1'b0, "crc16 check");

        beat(2, 64'h3837363534333231, 8, 1'b0);
        beat(2, 64'h39, 1, 1'b1);
        result(2, 32'hCBF43926, 1'b0, "crc32 check");

        beat(0, 64'h12, 1, 1'b0);
        abort = 1'b1;
        beat(0, 64'h55, 1, 1'b0);
        abort = 1'b0;
        beat(0, 64'hBE, 1, 1'b0);
        beat(0, 64'hEF, 1, 1'b1);
        result(0, 32'h92, 1'b0, "crc8 after abort");

        beat(0, 64'h0, 0, 1'b1);
        chk("empty valid", 32'(ovld[0]), 32'd1);
        chk("empty crc", ocrc[0], 32'hFF);
        #2 reset = 1'b1;
        #1;
        chk("async reset out_valid", 32'(ovld[0]), 32'd0);
        chk("async reset in_ready", 32'(ordy[0]), 32'd1);
        chk("async reset out_crc", ocrc[0], 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        repeat (3000) begin
            sel       = $urandom_range(0, 2);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            in_bytes  = 4'($urandom_range(0, 15));
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            abort     = ($urandom_range(0, 40) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
